// File: rtl/i2s_tx.sv
// -----------------------------------------------------------------------------
// i2s_tx - I2S serializer at the end of the effect chain.
//
// Takes one stereo sample per frame from the processed stream (data_i/vld_i),
// keeps a single pending sample, and shifts it out MSB first to an I2S DAC.
// The bit clock (sclk) and word select (lrck) are derived from clk.
//
// Optional build macro:
//   I2S_TX_LJ_EN  defined   -> left-justified format (MSB on the lrck edge)
//                 undefined -> standard I2S (MSB one sclk after the lrck edge)
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous, active-high reset
//   data_i    in   stereo sample {lc, rc}, two's complement
//   vld_i     in   single-cycle strobe qualifying data_i
//   sclk      out  I2S bit clock, SCLK_DIV clk cycles per half period
//   lrck      out  word select, 0 = left slot, 1 = right slot
//   sdata     out  serial data, changes only on sclk falling edges
//   underrun  out  1-cycle pulse: a frame started without a new sample
//   overrun   out  1-cycle pulse: the pending sample was overwritten unused
// -----------------------------------------------------------------------------
package sample_pkg;
    typedef struct packed {
        logic [23:0] lc;
        logic [23:0] rc;
    } sample_t;
endpackage

module i2s_tx
    import sample_pkg::*;
#(
    parameter int SCLK_DIV  = 4,
    parameter int SLOT_BITS = 32
) (
    input  logic    clk,
    input  logic    rst,
    input  sample_t data_i,
    input  logic    vld_i,
    output logic    sclk,
    output logic    lrck,
    output logic    sdata,
    output logic    underrun,
    output logic    overrun
);

    localparam int DATA_WIDTH = $bits(data_i.lc);
    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int CNT_W      = $clog2(FRAME_BITS);
    localparam int DIV_W      = (SCLK_DIV > 2) ? $clog2(SCLK_DIV) : 1;

    // Left word in the upper slot, right word in the lower slot, each
    // MSB-aligned to its slot and zero padded below.
    function automatic logic [FRAME_BITS-1:0] build_frame(input sample_t s);
        logic [FRAME_BITS-1:0] f;
        f = {FRAME_BITS{1'b0}};
        f[FRAME_BITS-1 -: DATA_WIDTH] = s.lc;
        f[SLOT_BITS-1  -: DATA_WIDTH] = s.rc;
        return f;
    endfunction

    logic [DIV_W-1:0]      r_div_cnt;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [FRAME_BITS-1:0] r_frame;
    sample_t               r_hold;
    logic                  r_hold_vld;
    logic                  r_sclk;
    logic                  r_lrck;
    logic                  r_sdata;
    logic                  r_underrun;
    logic                  r_overrun;

    logic                  w_div_wrap;
    logic                  w_fall;
    logic                  w_bit_last;
    logic                  w_load;
    logic [CNT_W-1:0]      w_bit_nxt;
    logic [FRAME_BITS-1:0] w_frame_nxt;
    logic                  w_sdata_nxt;

    // Divider/bit-counter decode, next frame word and next serial bit.
    always_comb begin
        w_div_wrap  = (r_div_cnt == DIV_W'(SCLK_DIV - 1));
        w_fall      = w_div_wrap & r_sclk;
        w_bit_last  = (r_bit_cnt == CNT_W'(FRAME_BITS - 1));
        w_load      = w_fall & w_bit_last;
        w_bit_nxt   = r_bit_cnt + CNT_W'(1);
        w_frame_nxt = r_frame;
        w_sdata_nxt = r_sdata;
        if (w_bit_last) begin
            w_bit_nxt = {CNT_W{1'b0}};
        end else begin
            w_bit_nxt = r_bit_cnt + CNT_W'(1);
        end
        // Without a pending sample the old frame word is simply replayed.
        if (w_load && r_hold_vld) begin
            w_frame_nxt = build_frame(r_hold);
        end else begin
            w_frame_nxt = r_frame;
        end
`ifdef I2S_TX_LJ_EN
        // Bit index follows the new count, so the MSB of a freshly loaded
        // word leaves on the same fall that drops lrck.
        w_sdata_nxt = w_frame_nxt[CNT_W'(FRAME_BITS - 1) - w_bit_nxt];
`else
        // One-bit delay: indexing with the old count gives bit (n-1) of the
        // current word, and at the wrap the last bit of the previous word
        // (the frame register still holds it until this edge).
        w_sdata_nxt = r_frame[CNT_W'(FRAME_BITS - 1) - r_bit_cnt];
`endif
    end

    // Clock divider and sclk generation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= {DIV_W{1'b0}};
            r_sclk    <= 1'b0;
        end else if (w_div_wrap) begin
            r_div_cnt <= {DIV_W{1'b0}};
            r_sclk    <= ~r_sclk;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    // Bit position, word select and serial data, all advanced on sclk falls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt <= CNT_W'(FRAME_BITS - 1);
            r_lrck    <= 1'b0;
            r_sdata   <= 1'b0;
        end else if (w_fall) begin
            r_bit_cnt <= w_bit_nxt;
            r_lrck    <= (w_bit_nxt >= CNT_W'(SLOT_BITS));
            r_sdata   <= w_sdata_nxt;
        end else begin
            r_bit_cnt <= r_bit_cnt;
        end
    end

    // Frame word, pending-sample register and stream flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame    <= {FRAME_BITS{1'b0}};
            r_hold     <= '0;
            r_hold_vld <= 1'b0;
            r_underrun <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_frame    <= w_frame_nxt;
            r_underrun <= w_load & ~r_hold_vld;
            // A strobe on the load cycle refills the slot just emptied.
            r_overrun  <= vld_i & r_hold_vld & ~w_load;
            if (vld_i) begin
                r_hold     <= data_i;
                r_hold_vld <= 1'b1;
            end else if (w_load) begin
                r_hold_vld <= 1'b0;
            end else begin
                r_hold_vld <= r_hold_vld;
            end
        end
    end

    assign sclk     = r_sclk;
    assign lrck     = r_lrck;
    assign sdata    = r_sdata;
    assign underrun = r_underrun;
    assign overrun  = r_overrun;

endmodule
